// File: rtl/picorv32_pcpi_hub_if.sv
// Purpose: bundles the picorv32 PCPI request/response signals with the broadcast coprocessor bus.
// Latency: none; this is wiring only.
// Backpressure: none here; flow control is the PCPI wait/ready/timeout protocol carried by these signals.
//
// Ports (signals):
//   core side : pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2 -> hub ; pcpi_wr, pcpi_rd, pcpi_wait,
//               pcpi_ready, pcpi_timeout <- hub
//   cp side   : cp_valid, cp_insn, cp_rs1, cp_rs2 <- hub ; cp_wr, cp_rd, cp_wait, cp_ready -> hub
//   modport slave  : the hub's view
//   modport master : the environment's view (core plus coprocessors)
interface picorv32_pcpi_hub_if #(
  parameter int NUM_CP = 2
);
  // core side
  logic                  pcpi_valid;
  logic [31:0]           pcpi_insn;
  logic [31:0]           pcpi_rs1;
  logic [31:0]           pcpi_rs2;
  logic                  pcpi_wr;
  logic [31:0]           pcpi_rd;
  logic                  pcpi_wait;
  logic                  pcpi_ready;
  logic                  pcpi_timeout;
  // coprocessor side
  logic                  cp_valid;
  logic [31:0]           cp_insn;
  logic [31:0]           cp_rs1;
  logic [31:0]           cp_rs2;
  logic [NUM_CP-1:0]     cp_wr;
  logic [32*NUM_CP-1:0]  cp_rd;
  logic [NUM_CP-1:0]     cp_wait;
  logic [NUM_CP-1:0]     cp_ready;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    output cp_valid, cp_insn, cp_rs1, cp_rs2,
    input  cp_wr, cp_rd, cp_wait, cp_ready
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    input  cp_valid, cp_insn, cp_rs1, cp_rs2,
    output cp_wr, cp_rd, cp_wait, cp_ready
  );
endinterface

// File: rtl/picorv32_pcpi_hub.sv
// Purpose: fans one picorv32 PCPI request out to NUM_CP coprocessors and returns one registered response.
// Latency: pcpi_valid -> cp_valid 1 cycle; cp_ready -> pcpi_ready 1 cycle; unclaimed timeout at TIMEOUT_CYCLES+1.
// Backpressure: the core holds pcpi_valid; the hub stalls it via pcpi_wait and closes with ready or timeout.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset; abandons any transaction in flight without a response
//   io_bus : picorv32_pcpi_hub_if.slave (core-side PCPI signals plus the coprocessor broadcast bus)
module picorv32_pcpi_hub #(
  parameter int NUM_CP         = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  picorv32_pcpi_hub_if.slave io_bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_TOUT,
    ST_DRAIN
  } state_t;

  // Counter value in the last REQ cycle that may still be claimed before timing out.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_claim;

  logic        r_cp_valid;
  logic [31:0] r_cp_insn;
  logic [31:0] r_cp_rs1;
  logic [31:0] r_cp_rs2;

  logic        r_pcpi_wr;
  logic [31:0] r_pcpi_rd;
  logic        r_pcpi_wait;
  logic        r_pcpi_ready;
  logic        r_pcpi_timeout;

  logic        w_any_ready;
  logic        w_claimed;
  logic        w_sel_wr;
  logic [31:0] w_sel_rd;

  // Lowest-index completing coprocessor wins. Scanning from the top down lets
  // the lowest set bit overwrite any higher one.
  always_comb begin
    w_sel_wr = 1'b0;
    w_sel_rd = 32'h0;
    for (int k = NUM_CP - 1; k >= 0; k--) begin
      if (io_bus.cp_ready[k]) begin
        w_sel_wr = io_bus.cp_wr[k];
        w_sel_rd = io_bus.cp_rd[32*k +: 32];
      end
    end
  end

  assign w_any_ready = |io_bus.cp_ready;
  // A claim arriving in the same cycle the counter expires still rescues the request.
  assign w_claimed   = r_claim | (|io_bus.cp_wait);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'h0;
      r_claim        <= 1'b0;
      r_cp_valid     <= 1'b0;
      r_cp_insn      <= 32'h0;
      r_cp_rs1       <= 32'h0;
      r_cp_rs2       <= 32'h0;
      r_pcpi_wr      <= 1'b0;
      r_pcpi_rd      <= 32'h0;
      r_pcpi_wait    <= 1'b0;
      r_pcpi_ready   <= 1'b0;
      r_pcpi_timeout <= 1'b0;
    end else begin
      // Response outputs are single-cycle; they are only raised on entry to RESP/TOUT.
      r_pcpi_ready   <= 1'b0;
      r_pcpi_timeout <= 1'b0;
      r_pcpi_wr      <= 1'b0;
      r_pcpi_rd      <= 32'h0;

      case (r_state)
        ST_IDLE: begin
          if (io_bus.pcpi_valid) begin
            r_cp_insn  <= io_bus.pcpi_insn;
            r_cp_rs1   <= io_bus.pcpi_rs1;
            r_cp_rs2   <= io_bus.pcpi_rs2;
            r_cnt      <= 8'h0;
            r_claim    <= 1'b0;
            r_cp_valid <= 1'b1;
            r_state    <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (!io_bus.pcpi_valid) begin
            // Core withdrew the request: drop the broadcast, no response.
            r_cp_valid  <= 1'b0;
            r_pcpi_wait <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_any_ready) begin
            // Completion beats a timeout expiring in the same cycle.
            r_cp_valid   <= 1'b0;
            r_pcpi_wait  <= 1'b0;
            r_pcpi_ready <= 1'b1;
            r_pcpi_wr    <= w_sel_wr;
            r_pcpi_rd    <= w_sel_rd;
            r_state      <= ST_RESP;
          end else if (!w_claimed && (r_cnt == LP_LAST)) begin
            r_cp_valid     <= 1'b0;
            r_pcpi_timeout <= 1'b1;
            r_state        <= ST_TOUT;
          end else if (w_claimed) begin
            r_claim     <= 1'b1;
            r_pcpi_wait <= 1'b1;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          r_state <= ST_DRAIN;
        end

        ST_TOUT: begin
          r_state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          // Holding here until the core drops valid guarantees a cp_valid-low
          // gap, so no coprocessor re-decodes the finished instruction.
          if (!io_bus.pcpi_valid) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_cp_valid  <= 1'b0;
          r_pcpi_wait <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.cp_valid     = r_cp_valid;
  assign io_bus.cp_insn      = r_cp_insn;
  assign io_bus.cp_rs1       = r_cp_rs1;
  assign io_bus.cp_rs2       = r_cp_rs2;
  assign io_bus.pcpi_wr      = r_pcpi_wr;
  assign io_bus.pcpi_rd      = r_pcpi_rd;
  assign io_bus.pcpi_wait    = r_pcpi_wait;
  assign io_bus.pcpi_ready   = r_pcpi_ready;
  assign io_bus.pcpi_timeout = r_pcpi_timeout;

endmodule
